// File: rtl/vpu_sram_rd_engine.sv
// Burst read master for one SRAM read port: issues credit-limited beats and streams returned data with a last flag.
// Optional beat/stall statistics outputs are built when VPU_SRAM_RD_ENGINE_STAT_EN is defined.
module vpu_sram_rd_engine #(
    parameter int DATA_WIDTH    = 512,
    parameter int BANK_ID_WIDTH = 2,
    parameter int ADDR_WIDTH    = 10,
    parameter int LEN_WIDTH     = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BANK_ID_WIDTH-1:0] cmd_bank,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic                     req,
    input  logic                     ack,
    output logic [BANK_ID_WIDTH-1:0] rid,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic                     reb,
    output logic                     rlast,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     rvalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_unexp
`ifdef VPU_SRAM_RD_ENGINE_STAT_EN
    ,
    output logic [31:0]              stat_beats,
    output logic [31:0]              stat_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     req_q, req_d;
    logic                     reb_q, reb_d;
    logic                     rlast_q, rlast_d;
    logic [BANK_ID_WIDTH-1:0] rid_q, rid_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]            outst_q, outst_d;
    logic [CW-1:0]            fcnt_q, fcnt_d;
    logic [CW-1:0]            pcnt_q, pcnt_d;
    logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]            pwptr_q, pwptr_d, prptr_q, prptr_d;
    logic [LEN_WIDTH-1:0]     rcnt_q, rcnt_d;
    logic                     err_q, err_d;

    logic [DATA_WIDTH-1:0]    mem_data [FIFO_DEPTH];
    logic                     mem_last [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]     plen     [FIFO_DEPTH];

    logic                     grant, cmd_fire, rsp_push, rsp_last, pop;
    logic                     pend_room, credit_ok;
    logic [CW:0]              used_d;

    always_comb begin
        grant    = req_q & ack;
        cmd_fire = cmd_valid & cmd_ready_q;
        rsp_push = rvalid & (outst_q != '0);
        rsp_last = (rcnt_q == plen[prptr_q]);
        pop      = (fcnt_q != '0) & out_ready;

        outst_d = outst_q;
        if (grant && !rsp_push) begin
            outst_d = outst_q + CW'(1);
        end else if (!grant && rsp_push) begin
            outst_d = outst_q - CW'(1);
        end

        fcnt_d = fcnt_q;
        if (rsp_push && !pop) begin
            fcnt_d = fcnt_q + CW'(1);
        end else if (!rsp_push && pop) begin
            fcnt_d = fcnt_q - CW'(1);
        end
        wptr_d = rsp_push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;

        // Pending-len queue: one entry per accepted burst until its last beat returns
        pcnt_d = pcnt_q;
        if (cmd_fire && !(rsp_push && rsp_last)) begin
            pcnt_d = pcnt_q + CW'(1);
        end else if (!cmd_fire && rsp_push && rsp_last) begin
            pcnt_d = pcnt_q - CW'(1);
        end
        pwptr_d = cmd_fire ? pwptr_q + PW'(1) : pwptr_q;
        prptr_d = (rsp_push && rsp_last) ? prptr_q + PW'(1) : prptr_q;
        rcnt_d  = rcnt_q;
        if (rsp_push) begin
            rcnt_d = rsp_last ? '0 : rcnt_q + LEN_WIDTH'(1);
        end

        err_d = err_q | (rvalid & (outst_q == '0));

        // Outputs are registered, so credit is judged on next-cycle occupancy
        used_d    = {1'b0, fcnt_d} + {1'b0, outst_d};
        credit_ok = used_d < (CW+1)'(FIFO_DEPTH);
        pend_room = pcnt_d != CW'(FIFO_DEPTH);

        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        req_d       = 1'b0;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = pend_room;
                if (cmd_fire) begin
                    state_d     = ISSUE;
                    cmd_ready_d = 1'b0;
                    rid_d       = cmd_bank;
                    addr_d      = cmd_addr;
                    cnt_d       = cmd_len;
                    rlast_d     = (cmd_len == '0);
                    req_d       = credit_ok;
                end
            end
            ISSUE: begin
                cmd_ready_d = 1'b0;
                req_d       = credit_ok;
                if (grant) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (rlast_q) begin
                        state_d     = IDLE;
                        cmd_ready_d = pend_room;
                        req_d       = 1'b0;
                        rlast_d     = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        rlast_d = (cnt_q == LEN_WIDTH'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        reb_d = ~req_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            reb_q       <= 1'b1;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            outst_q     <= '0;
            fcnt_q      <= '0;
            pcnt_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pwptr_q     <= '0;
            prptr_q     <= '0;
            rcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            reb_q       <= reb_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            fcnt_q      <= fcnt_d;
            pcnt_q      <= pcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pwptr_q     <= pwptr_d;
            prptr_q     <= prptr_d;
            rcnt_q      <= rcnt_d;
            err_q       <= err_d;
        end
    end

    // Storage arrays hold only data qualified by the pointers, so they carry no reset
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            mem_data[wptr_q] <= rdata;
            mem_last[wptr_q] <= rsp_last;
        end
        if (cmd_fire) begin
            plen[pwptr_q] <= cmd_len;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign req       = req_q;
    assign reb       = reb_q;
    assign rlast     = rlast_q;
    assign rid       = rid_q;
    assign addr      = addr_q;
    assign out_valid = (fcnt_q != '0);
    assign out_data  = mem_data[rptr_q];
    assign out_last  = mem_last[rptr_q];
    assign busy      = (state_q != IDLE) | (outst_q != '0) | (pcnt_q != '0);
    assign err_unexp = err_q;

`ifdef VPU_SRAM_RD_ENGINE_STAT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_beats_d = sat_inc(stat_beats_q, grant);
        stat_stall_d = sat_inc(stat_stall_q, (state_q == ISSUE) & ~grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_vpu_sram_rd_engine.sv
// Directed bench for vpu_sram_rd_engine: SRAM responder with fixed latency, logged grants and outputs.
module tb_vpu_sram_rd_engine;

    localparam int DW = 512;
    localparam int BW = 2;
    localparam int AW = 10;
    localparam int LW = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [BW-1:0] cmd_bank;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          req;
    logic          ack;
    logic [BW-1:0] rid;
    logic [AW-1:0] addr;
    logic          reb;
    logic          rlast;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          err_unexp;
`ifdef VPU_SRAM_RD_ENGINE_STAT_EN
    logic [31:0]   stat_beats;
    logic [31:0]   stat_stall;
`endif

    vpu_sram_rd_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .req(req), .ack(ack), .rid(rid), .addr(addr), .reb(reb), .rlast(rlast),
        .rdata(rdata), .rvalid(rvalid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_unexp(err_unexp)
`ifdef VPU_SRAM_RD_ENGINE_STAT_EN
        , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int ack_mode = 0;
    int lat = 1;
    logic inj = 1'b0;
    logic hs = 1'b0;
    int hs_cyc = 0;
    int lastg_cyc = 0;
    logic prev_wait = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_rid;
    logic prev_last;

    int            rq_due[$];
    logic [DW-1:0] rq_data[$];
    logic [AW-1:0] g_addr[$];
    logic [BW-1:0] g_rid[$];
    logic          g_last[$];
    logic [DW-1:0] o_data[$];
    logic          o_last[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [BW-1:0] b, input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 32] = 32'hC0FF_EE5A;
        d[AW-1:0] = a;
        d[AW+BW-1:AW] = b;
        d[300 +: AW] = ~a;
        return d;
    endfunction

    // Log what the coming edge will do, then advance one cycle and drive responder inputs.
    task automatic step();
        if (rst_n && req && ack) begin
            g_addr.push_back(addr);
            g_rid.push_back(rid);
            g_last.push_back(rlast);
            rq_due.push_back(cyc + lat);
            rq_data.push_back(mk(rid, addr));
            if (rlast) lastg_cyc = cyc;
        end
        if (rst_n && out_valid && out_ready) begin
            o_data.push_back(out_data);
            o_last.push_back(out_last);
        end
        if (rst_n && cmd_valid && cmd_ready) begin
            hs = 1'b1;
            hs_cyc = cyc;
        end
        if (prev_wait && rst_n) begin
            chk("hold_req", req, 1);
            chk("hold_addr", addr, prev_addr);
            chk("hold_rid", rid, prev_rid);
            chk("hold_rlast", rlast, prev_last);
        end
        prev_wait = rst_n && req && !ack;
        prev_addr = addr;
        prev_rid  = rid;
        prev_last = rlast;
        @(negedge clk);
        cyc++;
        ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? ((cyc % 2) == 1) : 1'b0;
        rvalid = 1'b0;
        if (inj) begin
            rvalid = 1'b1;
            rdata = mk(2'd3, 10'h2AA);
            inj = 1'b0;
        end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata = rq_data.pop_front();
            void'(rq_due.pop_front());
        end
    endtask

    task automatic send_cmd(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        cmd_bank = b;
        cmd_addr = a;
        cmd_len = l;
        cmd_valid = 1'b1;
        hs = 1'b0;
        while (!hs && n < 50) begin
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_hs", hs, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || out_valid || rq_due.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("idle", busy | out_valid, 0);
    endtask

    task automatic clear_logs();
        g_addr.delete();
        g_rid.delete();
        g_last.delete();
        o_data.delete();
        o_last.delete();
    endtask

    task automatic chk_beats(input int gi, input logic [BW-1:0] b, input logic [AW-1:0] a0, input int n);
        logic [AW-1:0] ea;
        for (int i = 0; i < n; i++) begin
            ea = a0 + i[AW-1:0];
            chk("g_addr", g_addr[gi+i], ea);
            chk("g_rid", g_rid[gi+i], b);
            chk("g_rlast", g_last[gi+i], (i == n - 1));
            chk("o_data", o_data[gi+i], mk(b, ea));
            chk("o_last", o_last[gi+i], (i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_bank = '0;
        cmd_addr = '0;
        cmd_len = '0;
        ack = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_reb", reb, 1);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_unexp, 0);
        rst_n = 1'b1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Single beat
        lat = 5;
        out_ready = 1'b1;
        clear_logs();
        send_cmd(2'd1, 10'h010, 4'd0);
        wait_idle(60);
        chk("single_ngrant", g_addr.size(), 1);
        chk("single_nout", o_data.size(), 1);
        chk_beats(0, 2'd1, 10'h010, 1);
        chk("single_busy", busy, 0);

        // Burst with ack every other cycle
        ack_mode = 1;
        lat = 2;
        clear_logs();
        send_cmd(2'd2, 10'h100, 4'd3);
        wait_idle(100);
        chk("burst_ngrant", g_addr.size(), 4);
        chk("burst_nout", o_data.size(), 4);
        chk_beats(0, 2'd2, 10'h100, 4);
        ack_mode = 0;

        // Credit stall with consumer blocked
        out_ready = 1'b0;
        lat = 2;
        clear_logs();
        send_cmd(2'd3, 10'h200, 4'd15);
        repeat (30) step();
        chk("credit_ngrant8", g_addr.size(), 8);
        chk("credit_req", req, 0);
        chk("credit_reb", reb, 1);
        chk("credit_out_valid", out_valid, 1);
        chk("credit_busy", busy, 1);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        repeat (20) step();
        chk("credit_ngrant11", g_addr.size(), 11);
        chk("credit_npop3", o_data.size(), 3);
        chk("credit_req2", req, 0);
        out_ready = 1'b1;
        wait_idle(200);
        chk("credit_nout", o_data.size(), 16);
        chk_beats(0, 2'd3, 10'h200, 16);

        // Address wrap
        lat = 1;
        clear_logs();
        send_cmd(2'd1, 10'h3FE, 4'd3);
        wait_idle(60);
        chk("wrap_ngrant", g_addr.size(), 4);
        chk("wrap_addr2", g_addr[2], 10'h000);
        chk_beats(0, 2'd1, 10'h3FE, 4);

        // Back-to-back bursts overlapping in the response path
        lat = 3;
        clear_logs();
        send_cmd(2'd0, 10'h020, 4'd1);
        send_cmd(2'd2, 10'h030, 4'd1);
        chk("b2b_gap", hs_cyc, lastg_cyc + 1);
        wait_idle(60);
        chk("b2b_nout", o_data.size(), 4);
        chk_beats(0, 2'd0, 10'h020, 2);
        chk_beats(2, 2'd2, 10'h030, 2);

        // Unexpected rvalid
        chk("err_pre", err_unexp, 0);
        inj = 1'b1;
        step();
        step();
        chk("err_set", err_unexp, 1);
        chk("err_out_valid", out_valid, 0);
        repeat (3) step();
        chk("err_out_valid2", out_valid, 0);
        chk("err_sticky", err_unexp, 1);

        // Reset mid-burst, then late responses
        lat = 8;
        clear_logs();
        send_cmd(2'd0, 10'h040, 4'd7);
        repeat (3) step();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        prev_wait = 1'b0;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_reb", reb, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_unexp, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        step();
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (!err_unexp && n < 30) begin
                step();
                n++;
            end
        end
        chk("late_rvalid_err", err_unexp, 1);
        chk("late_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
